// File: rtl/tlb_pkg.sv
// -----------------------------------------------------------------------------
// tlb_pkg -- shared types and helpers for the TLB slice.
//   Field widths, the stored entry layout, the page-half view that a search
//   returns, the invalidate FSM state type and a page-half selector.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package tlb_pkg;

  localparam int VPN2_W = 19;
  localparam int ASID_W = 8;
  localparam int PFN_W  = 20;
  localparam int C_W    = 3;

  // One TLB entry minus its valid bit; the valid bits live in a separate
  // vector so they alone can be reset.
  typedef struct packed {
    logic [VPN2_W-1:0] vpn2;
    logic [ASID_W-1:0] asid;
    logic              g;
    logic [PFN_W-1:0]  pfn0;
    logic [C_W-1:0]    c0;
    logic              d0;
    logic              v0;
    logic [PFN_W-1:0]  pfn1;
    logic [C_W-1:0]    c1;
    logic              d1;
    logic              v1;
  } tlb_entry_t;

  // The even or odd page half of an entry, as delivered by a search.
  typedef struct packed {
    logic [PFN_W-1:0] pfn;
    logic [C_W-1:0]   c;
    logic             d;
    logic             v;
  } tlb_page_t;

  typedef enum logic {INV_IDLE, INV_SWEEP} inv_state_t;

  function automatic tlb_page_t sel_page(input tlb_entry_t ent, input logic odd);
    tlb_page_t p;
    if (odd) begin
      p.pfn = ent.pfn1; p.c = ent.c1; p.d = ent.d1; p.v = ent.v1;
    end else begin
      p.pfn = ent.pfn0; p.c = ent.c0; p.d = ent.d0; p.v = ent.v0;
    end
    return p;
  endfunction

endpackage

// File: rtl/tlb_match.sv
// -----------------------------------------------------------------------------
// tlb_match -- combinational lookup of one search key against all entries.
//   ents/e      : entry table and per-entry valid bits
//   vpn2/asid   : search key
//   found/index : any hit, and the lowest hitting index (0 on a miss)
//   multi       : two or more entries hit (only with TLB_MULTIHIT_DET_EN)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tlb_match
  import tlb_pkg::*;
#(
  parameter  int TLBNUM = 16,
  localparam int IDXW   = $clog2(TLBNUM)
) (
  input  tlb_entry_t          ents [TLBNUM],
  input  logic [TLBNUM-1:0]   e,
  input  logic [VPN2_W-1:0]   vpn2,
  input  logic [ASID_W-1:0]   asid,
`ifdef TLB_MULTIHIT_DET_EN
  output logic                multi,
`endif
  output logic                found,
  output logic [IDXW-1:0]     index
);

  logic [TLBNUM-1:0] hit;

  // NOTE: combinational blocks use blocking '=' so each statement sees the
  // value written just above it; registers elsewhere use '<=' only.
  always_comb begin
    for (int i = 0; i < TLBNUM; i++) begin
      hit[i] = e[i] && (ents[i].vpn2 == vpn2) && ((ents[i].asid == asid) || ents[i].g);
    end
  end

  // Walk from the top so the lowest hitting index is the last one written.
  // NOTE: index gets a default before the loop so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    index = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (hit[i]) index = IDXW'(i);
    end
  end

  assign found = |hit;

`ifdef TLB_MULTIHIT_DET_EN
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi = |(hit & (hit - TLBNUM'(1)));
`endif

endmodule

// File: rtl/tlb_pipe.sv
// -----------------------------------------------------------------------------
// tlb_pipe -- fully associative TLB with two registered search ports, one
//   write port, a combinational read port, an invalidate sweep and a random
//   replacement index.
//   clk, reset        : clock, asynchronous active-high reset
//   s0_*/s1_*         : search request/key in, registered result one cycle later
//   we, w_*           : entry write (sets the entry valid)
//   r_index, r_*      : combinational read of one entry, r_e = entry valid
//   inv_req/all/asid  : start a sweep (clear all, or non-global entries of asid)
//   inv_busy          : sweep in progress, one entry per cycle
//   wired, rnd_index  : random index counts down, reloading at wired
//   multihit          : present only with macro TLB_MULTIHIT_DET_EN defined
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tlb_pipe
  import tlb_pkg::*;
#(
  parameter  int TLBNUM = 16,
  localparam int IDXW   = $clog2(TLBNUM)
) (
  input  logic              clk,
  input  logic              reset,
`ifdef TLB_MULTIHIT_DET_EN
  output logic              multihit,
`endif
  // search port 0
  input  logic              s0_req,
  input  logic [VPN2_W-1:0] s0_vpn2,
  input  logic              s0_odd_page,
  input  logic [ASID_W-1:0] s0_asid,
  output logic              s0_rvalid,
  output logic              s0_found,
  output logic [IDXW-1:0]   s0_index,
  output logic [PFN_W-1:0]  s0_pfn,
  output logic [C_W-1:0]    s0_c,
  output logic              s0_d,
  output logic              s0_v,
  // search port 1
  input  logic              s1_req,
  input  logic [VPN2_W-1:0] s1_vpn2,
  input  logic              s1_odd_page,
  input  logic [ASID_W-1:0] s1_asid,
  output logic              s1_rvalid,
  output logic              s1_found,
  output logic [IDXW-1:0]   s1_index,
  output logic [PFN_W-1:0]  s1_pfn,
  output logic [C_W-1:0]    s1_c,
  output logic              s1_d,
  output logic              s1_v,
  // write port
  input  logic              we,
  input  logic [IDXW-1:0]   w_index,
  input  logic [VPN2_W-1:0] w_vpn2,
  input  logic [ASID_W-1:0] w_asid,
  input  logic              w_g,
  input  logic [PFN_W-1:0]  w_pfn0,
  input  logic [C_W-1:0]    w_c0,
  input  logic              w_d0,
  input  logic              w_v0,
  input  logic [PFN_W-1:0]  w_pfn1,
  input  logic [C_W-1:0]    w_c1,
  input  logic              w_d1,
  input  logic              w_v1,
  // read port
  input  logic [IDXW-1:0]   r_index,
  output logic [VPN2_W-1:0] r_vpn2,
  output logic [ASID_W-1:0] r_asid,
  output logic              r_g,
  output logic [PFN_W-1:0]  r_pfn0,
  output logic [C_W-1:0]    r_c0,
  output logic              r_d0,
  output logic              r_v0,
  output logic [PFN_W-1:0]  r_pfn1,
  output logic [C_W-1:0]    r_c1,
  output logic              r_d1,
  output logic              r_v1,
  output logic              r_e,
  // invalidate sweep
  input  logic              inv_req,
  input  logic              inv_all,
  input  logic [ASID_W-1:0] inv_asid,
  output logic              inv_busy,
  // random replacement
  input  logic [IDXW-1:0]   wired,
  output logic [IDXW-1:0]   rnd_index
);

  localparam logic [IDXW-1:0] LAST = IDXW'(TLBNUM - 1);

  tlb_entry_t        ents [TLBNUM];
  logic [TLBNUM-1:0] e;
  tlb_entry_t        w_ent;

  inv_state_t        inv_state, inv_state_nxt;
  logic [IDXW-1:0]   inv_ptr;
  logic              inv_all_q;
  logic [ASID_W-1:0] inv_asid_q;
  logic              sweep_clr;

  logic              m0_found, m1_found;
  logic [IDXW-1:0]   m0_index, m1_index;
  tlb_page_t         pg0, pg1, s0_pg_q, s1_pg_q;

  // ---------------- lookup ----------------
  // Searches see the table as it stood before this edge's write or sweep step.
`ifdef TLB_MULTIHIT_DET_EN
  logic m0_multi, m1_multi;
`endif

  tlb_match #(.TLBNUM(TLBNUM)) u_match0 (
    .ents(ents), .e(e), .vpn2(s0_vpn2), .asid(s0_asid),
`ifdef TLB_MULTIHIT_DET_EN
    .multi(m0_multi),
`endif
    .found(m0_found), .index(m0_index)
  );

  tlb_match #(.TLBNUM(TLBNUM)) u_match1 (
    .ents(ents), .e(e), .vpn2(s1_vpn2), .asid(s1_asid),
`ifdef TLB_MULTIHIT_DET_EN
    .multi(m1_multi),
`endif
    .found(m1_found), .index(m1_index)
  );

  assign pg0 = m0_found ? sel_page(ents[m0_index], s0_odd_page) : '0;
  assign pg1 = m1_found ? sel_page(ents[m1_index], s1_odd_page) : '0;

  // Result registers load only on a request and otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s0_rvalid <= 1'b0; s0_found <= 1'b0; s0_index <= '0; s0_pg_q <= '0;
      s1_rvalid <= 1'b0; s1_found <= 1'b0; s1_index <= '0; s1_pg_q <= '0;
    end else begin
      s0_rvalid <= s0_req;
      s1_rvalid <= s1_req;
      if (s0_req) begin
        s0_found <= m0_found; s0_index <= m0_index; s0_pg_q <= pg0;
      end
      if (s1_req) begin
        s1_found <= m1_found; s1_index <= m1_index; s1_pg_q <= pg1;
      end
    end
  end

  assign {s0_pfn, s0_c, s0_d, s0_v} = s0_pg_q;
  assign {s1_pfn, s1_c, s1_d, s1_v} = s1_pg_q;

`ifdef TLB_MULTIHIT_DET_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) multihit <= 1'b0;
    else       multihit <= (s0_req && m0_multi) || (s1_req && m1_multi);
  end
`endif

  // ---------------- table storage ----------------
  assign w_ent = '{vpn2: w_vpn2, asid: w_asid, g: w_g,
                   pfn0: w_pfn0, c0: w_c0, d0: w_d0, v0: w_v0,
                   pfn1: w_pfn1, c1: w_c1, d1: w_d1, v1: w_v1};

  // NOTE: the entry array is deliberately left without reset; only the valid
  // bits need a known state, and a reset-free array maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (we) ents[w_index] <= w_ent;
  end

  // A write issued in the same cycle as the sweep step on that entry is the
  // later assignment, so the entry stays valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e <= '0;
    end else begin
      if (sweep_clr) e[inv_ptr] <= 1'b0;
      if (we)        e[w_index] <= 1'b1;
    end
  end

  assign r_e = e[r_index];
  assign {r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0,
          r_pfn1, r_c1, r_d1, r_v1} = ents[r_index];

  // ---------------- invalidate sweep ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) inv_state <= INV_IDLE;
    else       inv_state <= inv_state_nxt;
  end

  always_comb begin
    inv_state_nxt = inv_state;
    case (inv_state)
      INV_IDLE:  if (inv_req)          inv_state_nxt = INV_SWEEP;
      INV_SWEEP: if (inv_ptr == LAST)  inv_state_nxt = INV_IDLE;
      default:                         inv_state_nxt = INV_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inv_ptr    <= '0;
      inv_all_q  <= 1'b0;
      inv_asid_q <= '0;
    end else if (inv_state == INV_IDLE) begin
      if (inv_req) begin
        inv_ptr    <= '0;
        inv_all_q  <= inv_all;
        inv_asid_q <= inv_asid;
      end
    end else begin
      inv_ptr <= inv_ptr + IDXW'(1);
    end
  end

  // Gating on e keeps never-written entries (unknown fields) out of the test.
  assign sweep_clr = (inv_state == INV_SWEEP) && e[inv_ptr] &&
                     (inv_all_q || ((ents[inv_ptr].asid == inv_asid_q) && !ents[inv_ptr].g));
  assign inv_busy  = (inv_state == INV_SWEEP);

  // ---------------- random replacement ----------------
  // Reloading on equality also holds the counter at LAST when wired == LAST.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 rnd_index <= LAST;
    else if (rnd_index == wired) rnd_index <= LAST;
    else                       rnd_index <= rnd_index - IDXW'(1);
  end

endmodule

// File: doc/tlb_pipe.md
TLB_PIPE -- requirements
Module: tlb_pipe

Interface
REQ-001 SHALL have parameter TLBNUM, default 16, entry count (power of two, 4..64).
REQ-002 SHALL derive localparam IDXW = $clog2(TLBNUM), the index width.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have s0_req, s0_vpn2[18:0], s0_odd_page and s0_asid[7:0] as inputs: search request and key.
REQ-006 SHALL have s0_rvalid, s0_found, s0_index[IDXW-1:0], s0_pfn[19:0], s0_c[2:0], s0_d and s0_v as registered search-result outputs.
REQ-007 SHALL have search port 1 with signals s1_* identical to s0_*.
REQ-008 SHALL have write-port inputs we, w_index[IDXW-1:0], w_vpn2, w_asid, w_g, w_pfn0/1, w_c0/1, w_d0/1 and w_v0/1 (widths as search port).
REQ-009 SHALL have r_index as input and r_vpn2, r_asid, r_g, r_pfn0/1, r_c0/1, r_d0/1, r_v0/1 and r_e (entry-valid) as combinational read outputs.
REQ-010 SHALL have inputs inv_req, inv_all and inv_asid[7:0], and output inv_busy, for the invalidate sweep.
REQ-011 SHALL have input wired[IDXW-1:0] and output rnd_index[IDXW-1:0] for random replacement.

Function
REQ-012 SHALL define a match on entry i as e[i] && vpn2 equal && (asid equal || g[i]).
REQ-013 SHALL sample a search when sN_req=1 at a posedge and present its result one cycle later, with sN_rvalid high for exactly that one cycle.
REQ-014 SHALL select the lowest matching index on multiple matches.
REQ-015 SHALL take pfn/c/d/v from set 1 when odd_page=1 and from set 0 otherwise.
REQ-016 SHALL drive found=0 and index/pfn/c/d/v=0 on a miss.
REQ-017 SHALL, when a write and a search occur in the same cycle, return the pre-write table contents for that search.
REQ-018 SHALL update all fields of entry w_index and set e=1 at the posedge on which we=1.
REQ-019 SHALL implement the invalidate FSM states IDLE and SWEEP.
REQ-020 SHALL, in IDLE, move to SWEEP and latch inv_all/inv_asid when inv_req=1, with pointer=0.
REQ-021 SHALL, in SWEEP, visit one entry per cycle and clear e when inv_all=1, or when asid==inv_asid and g=0.
REQ-022 SHALL return from SWEEP to IDLE after pointer TLBNUM-1, so that a sweep takes exactly TLBNUM cycles.
REQ-023 SHALL hold inv_busy=1 throughout SWEEP and ignore inv_req while busy.
REQ-024 SHALL let a write win (e=1) when a write targets the sweep pointer in the same cycle.
REQ-025 SHALL allow searches and writes during SWEEP.
REQ-026 SHALL decrement rnd_index every cycle and reload it to TLBNUM-1 when it equals wired.
REQ-027 SHALL hold rnd_index at TLBNUM-1 when wired=TLBNUM-1.
REQ-028 SHALL, on a write with w_index==rnd_index, not alter the rnd_index sequence.

Reset
REQ-029 SHALL, while reset=1, immediately clear all e bits and force rvalid, found, index, pfn, c, d, v and inv_busy to 0, the FSM to IDLE and rnd_index to TLBNUM-1.
REQ-030 SHALL abort an in-progress sweep and discard in-flight search results on reset.
REQ-031 SHALL leave the entry fields other than e uninitialised.

Configuration
REQ-032 SHALL, with macro TLB_MULTIHIT_DET_EN defined, add output multihit, registered with the search results and high for one cycle when either sampled search matched two or more entries.
REQ-033 SHALL, without TLB_MULTIHIT_DET_EN, omit the multihit port and its logic, with all other behaviour identical.

Structure
REQ-034 SHALL place the field-width constants VPN2_W=19, ASID_W=8, PFN_W=20 and C_W=3 and typedef tlb_entry_t in package tlb_pkg.
REQ-035 SHALL use sub-module tlb_match (match vector, lowest-index priority encode, optional multi-hit flag), instantiated once per search port.

Verification
REQ-036 SHALL cover: write idx 3 {vpn2=0x12345, asid=0x05, g=0, pfn1=0xABCDE, v1=1}; s0 search vpn2=0x12345, odd=1, asid=0x05 -> next cycle rvalid=1, found=1, index=3, pfn=0xABCDE, v=1.
REQ-037 SHALL cover: same entry searched on s1 with asid=0x06 -> found=0; then rewrite with g=1 and search again -> found=1.
REQ-038 SHALL cover: entries 2 and 7 holding identical vpn2/asid -> index=2 and (macro on) multihit=1.
REQ-039 SHALL cover: entries 0..15 with asid=0x09 (entry 4 with g=1) and inv_req, inv_all=0, inv_asid=0x09 -> inv_busy high for 16 cycles, after which only entry 4 has r_e=1.
REQ-040 SHALL cover: wired=12 after reset -> rnd_index sequence 15,14,13,12,15,...
REQ-041 SHALL cover: reset asserted at sweep pointer 5 -> inv_busy=0 and all r_e=0 in the same cycle, with no rvalid in the following cycle.
